// File: rtl/io_pkg.sv
// Shared types and default addresses for the CPU-facing I/O register block.
package io_pkg;

    typedef logic [3:0]  led_t;
    typedef logic [15:0] sw_t;

    localparam logic [31:0] LED_ADDR_DFLT  = 32'h0000_FFF0;
    localparam logic [31:0] SW_ADDR_DFLT   = 32'h0000_FFF4;
    localparam logic [31:0] STAT_ADDR_DFLT = 32'h0000_FFF8;

    localparam int unsigned STAT_SWCHG_BIT = 0;

    // Zero-extend a narrow register value onto the 32-bit load bus.
    function automatic logic [31:0] zext_led(input led_t v);
        return {28'b0, v};
    endfunction

    function automatic logic [31:0] zext_sw(input sw_t v);
        return {16'b0, v};
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch conditioner: two-flop synchroniser, then (with DEBOUNCE_EN defined)
// a tick prescaler and 3-sample per-bit debounce. Without DEBOUNCE_EN the
// synchronised vector is used directly. Emits a one-cycle pulse the cycle
// after the conditioned vector changes.
module sw_debounce
    import io_pkg::*;
#(
    parameter int unsigned DEB_TICK = 100000,
    parameter int unsigned TICK_W   = 17
) (
    input  logic clk,
    input  logic reset,
    input  sw_t  raw,
    output sw_t  stable,
    output logic changed
);

    sw_t  sync1_q;
    sw_t  sync2_q;
    sw_t  stable_w;
    sw_t  prev_q;
    logic changed_q;

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef DEBOUNCE_EN
    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;
    logic              tick;
    sw_t               hist0_q, hist1_q, hist2_q;
    sw_t               hist0_d, hist1_d, hist2_d;
    sw_t               stable_q;
    sw_t               stable_d;

    // Prescaler wrap, history shift on tick and the all-equal debounce rule.
    always_comb begin
        tick    = (tick_q == TICK_W'(DEB_TICK - 1));
        tick_d  = tick ? '0 : tick_q + TICK_W'(1);
        hist0_d = hist0_q;
        hist1_d = hist1_q;
        hist2_d = hist2_q;
        if (tick) begin
            hist0_d = sync2_q;
            hist1_d = hist0_q;
            hist2_d = hist1_q;
        end
        // A bit goes to 1 when all three samples are 1, to 0 when all are 0,
        // otherwise it keeps its current value.
        stable_d = (hist0_d & hist1_d & hist2_d)
                 | (stable_q & (hist0_d | hist1_d | hist2_d));
    end

    // Prescaler, sample history and debounced vector registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q   <= '0;
            hist0_q  <= '0;
            hist1_q  <= '0;
            hist2_q  <= '0;
            stable_q <= '0;
        end else begin
            tick_q   <= tick_d;
            hist0_q  <= hist0_d;
            hist1_q  <= hist1_d;
            hist2_q  <= hist2_d;
            stable_q <= stable_d;
        end
    end

    assign stable_w = stable_q;
`else
    // Prescale settings only matter when debouncing is built in.
    localparam int unsigned deb_cfg_unused = DEB_TICK + TICK_W;

    assign stable_w = sync2_q;
`endif

    // Change detector: the pulse lands one cycle after the vector changes.
    // Reset clears both sides of the compare, so reset itself never pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            prev_q    <= stable_w;
            changed_q <= (stable_w != prev_q);
        end
    end

    assign stable  = stable_w;
    assign changed = changed_q;

endmodule

// File: rtl/mmio_io_regs.sv
// Memory-mapped LED/switch registers beside data RAM on the CPU data port.
// Build option: define DEBOUNCE_EN to include the switch debounce stage;
// otherwise switches are only synchronised.
module mmio_io_regs
    import io_pkg::*;
#(
    parameter int unsigned DEB_TICK  = 100000,
    parameter int unsigned TICK_W    = 17,
    parameter logic [31:0] LED_ADDR  = LED_ADDR_DFLT,
    parameter logic [31:0] SW_ADDR   = SW_ADDR_DFLT,
    parameter logic [31:0] STAT_ADDR = STAT_ADDR_DFLT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sw,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    output logic        io_hit,
    output logic [3:0]  led,
    output logic        sw_changed
);

    logic hit_led;
    logic hit_sw;
    logic hit_stat;
    led_t led_q, led_d;
    logic sticky_q, sticky_d;
    sw_t  sw_db;
    logic sw_chg;
    logic wdata_unused;

    // Only the low nibble of a store reaches the LED register.
    assign wdata_unused = ^mem_wdata[31:4];

    sw_debounce #(
        .DEB_TICK (DEB_TICK),
        .TICK_W   (TICK_W)
    ) u_sw_debounce (
        .clk     (clk),
        .reset   (reset),
        .raw     (sw),
        .stable  (sw_db),
        .changed (sw_chg)
    );

    // Word address decode.
    always_comb begin
        hit_led  = (mem_addr == LED_ADDR);
        hit_sw   = (mem_addr == SW_ADDR);
        hit_stat = (mem_addr == STAT_ADDR);
        io_hit   = hit_led | hit_sw | hit_stat;
    end

    // Next state: LED store, and sticky flag where a new change beats a clear.
    always_comb begin
        led_d = led_q;
        if (mem_we && hit_led) begin
            led_d = mem_wdata[3:0];
        end
        sticky_d = sw_chg | (sticky_q & ~(mem_re & hit_sw));
    end

    // LED and sticky-flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            led_q    <= led_d;
            sticky_q <= sticky_d;
        end
    end

    // Zero-wait-state load mux from registered state; a same-cycle store
    // to the LED register is not visible until the following cycle.
    always_comb begin
        mem_rdata = '0;
        if (hit_led) begin
            mem_rdata = zext_led(led_q);
        end else if (hit_sw) begin
            mem_rdata = zext_sw(sw_db);
        end else if (hit_stat) begin
            mem_rdata[STAT_SWCHG_BIT] = sticky_q;
        end
    end

    assign led        = led_q;
    assign sw_changed = sw_chg;

endmodule

// File: tb/tb_mmio_io_regs.sv
// Self-checking bench for mmio_io_regs: directed scenarios plus randomized
// traffic, all compared against a cycle-indexed behavioural model.
module tb_mmio_io_regs;

    localparam int unsigned DEB   = 4;
    localparam logic [31:0] A_LED  = 32'h0000_FFF0;
    localparam logic [31:0] A_SW   = 32'h0000_FFF4;
    localparam logic [31:0] A_STAT = 32'h0000_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sw = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_we = 1'b0;
    logic        mem_re = 1'b0;
    logic [31:0] mem_rdata;
    logic        io_hit;
    logic [3:0]  led;
    logic        sw_changed;

    mmio_io_regs #(
        .DEB_TICK (DEB),
        .TICK_W   (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw         (sw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .io_hit     (io_hit),
        .led        (led),
        .sw_changed (sw_changed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: k counts cycles since reset release.
    int          k;
    logic [15:0] sw_drv [0:8191];
    logic [15:0] samp [$];
    logic [15:0] m_stable, m_prev1, m_prev2;
    logic [3:0]  m_led;
    logic        m_sticky;

    logic [31:0] obs_rdata;
    logic        obs_hit;
    logic        obs_chg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    // Debounced switch value the bench expects to see during cycle k.
    task automatic model_stable();
        logic [15:0] s;
        m_prev2 = m_prev1;
        m_prev1 = m_stable;
`ifdef DEBOUNCE_EN
        // A sample is taken on the edge ending every DEB-th cycle; it sees
        // the switches as they were driven two cycles before that.
        if (k >= 1 && ((k - 1) % DEB) == DEB - 1) begin
            s = (k - 1 >= 2) ? sw_drv[k - 3] : 16'h0000;
            samp.push_back(s);
            if (samp.size() > 3) void'(samp.pop_front());
            for (int b = 0; b < 16; b++) begin
                if (samp[0][b] == samp[1][b] && samp[1][b] == samp[2][b])
                    m_stable[b] = samp[2][b];
            end
        end
`else
        m_stable = (k >= 2) ? sw_drv[k - 2] : 16'h0000;
`endif
    endtask

    task automatic do_reset(input int n, input logic [15:0] swv);
        reset    = 1'b1;
        sw       = swv;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = A_SW;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("rst_led", {28'b0, led}, 32'h0);
            check("rst_chg", {31'b0, sw_changed}, 32'h0);
            check("rst_swrd", mem_rdata, 32'h0);
        end
        k        = 0;
        m_stable = '0;
        m_prev1  = '0;
        m_prev2  = '0;
        m_led    = '0;
        m_sticky = 1'b0;
        samp.delete();
        repeat (3) samp.push_back(16'h0000);
    endtask

    // One bus cycle: drive, compare every output against the model, advance.
    task automatic step(input logic [15:0] swv, input logic [31:0] addr,
                        input logic we, input logic re, input logic [31:0] wd);
        logic        exp_chg;
        logic [31:0] exp_rd;
        logic        exp_hit;
        reset     = 1'b0;
        sw        = swv;
        mem_addr  = addr;
        mem_we    = we;
        mem_re    = re;
        mem_wdata = wd;
        sw_drv[k] = swv;
        model_stable();
        exp_chg = (m_prev1 != m_prev2);
        exp_hit = (addr == A_LED) || (addr == A_SW) || (addr == A_STAT);
        if (addr == A_LED)       exp_rd = {28'b0, m_led};
        else if (addr == A_SW)   exp_rd = {16'b0, m_stable};
        else if (addr == A_STAT) exp_rd = {31'b0, m_sticky};
        else                     exp_rd = 32'h0;
        @(negedge clk);
        check("rdata", mem_rdata, exp_rd);
        check("io_hit", {31'b0, io_hit}, {31'b0, exp_hit});
        check("led", {28'b0, led}, {28'b0, m_led});
        check("sw_changed", {31'b0, sw_changed}, {31'b0, exp_chg});
        obs_rdata = mem_rdata;
        obs_hit   = io_hit;
        obs_chg   = sw_changed;
        m_sticky  = exp_chg | (m_sticky & !(re && addr == A_SW));
        if (we && addr == A_LED) m_led = wd[3:0];
        k++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          pulses;
        int          first5;
        bit          seen;
        logic [15:0] cur;
        logic [31:0] addrs [6];
        int          hold;

        // Reset with all switches up; nothing may leak through.
        do_reset(2, 16'hFFFF);

        // Hold 0x0005 and wait for it to come through the conditioner.
        pulses = 0;
        first5 = -1;
        for (int i = 0; i < 20; i++) begin
            step(16'h0005, A_SW, 1'b0, 1'b0, 32'h0);
            if (obs_chg) pulses++;
            if (obs_rdata == 32'h5 && first5 < 0) first5 = k - 1;
        end
        check("sw5_pulses", pulses, 1);
        check("sw5_latency_ok", {31'b0, (first5 >= 0 && first5 <= 14)}, 32'h1);
        step(16'h0005, A_STAT, 1'b0, 1'b0, 32'h0);
        check("stat_after_change", obs_rdata, 32'h1);

        // LED store, readback and ignored stores.
        step(16'h0005, A_LED, 1'b1, 1'b0, 32'hABCD_1239);
        step(16'h0005, A_LED, 1'b0, 1'b0, 32'h0);
        check("led_store", {28'b0, led}, 32'h9);
        check("led_read", obs_rdata, 32'h9);
        step(16'h0005, A_LED, 1'b1, 1'b1, 32'h0000_0003);
        check("led_rw_old", obs_rdata, 32'h9);
        step(16'h0005, A_LED, 1'b0, 1'b0, 32'h0);
        check("led_rw_new", obs_rdata, 32'h3);
        step(16'h0005, A_SW, 1'b1, 1'b0, 32'hFFFF_FFFF);
        step(16'h0005, A_STAT, 1'b1, 1'b0, 32'hFFFF_FFFF);
        step(16'h0005, 32'h0000_FFFC, 1'b1, 1'b0, 32'h0000_0007);
        check("hit_fffc", {31'b0, obs_hit}, 32'h0);
        step(16'h0005, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_000E);
        check("hit_zero", {31'b0, obs_hit}, 32'h0);
        check("rd_zero", obs_rdata, 32'h0);
        step(16'h0005, A_LED, 1'b0, 1'b0, 32'h0);
        check("led_unchanged", obs_rdata, 32'h3);

        // Bit 0 chattering with a 3-cycle half period, ending on its old value.
        pulses = 0;
        for (int i = 0; i < 39; i++) begin
            step(((i / 3) % 2 == 0) ? 16'h0005 : 16'h0004, A_SW, 1'b0, 1'b0, 32'h0);
            if (obs_chg) pulses++;
        end
`ifdef DEBOUNCE_EN
        check("chatter_pulses", pulses, 0);
`else
        check("chatter_follows", {31'b0, (pulses >= 8)}, 32'h1);
`endif
        for (int i = 0; i < 20; i++) step(16'h0005, A_SW, 1'b1, 1'b1, 32'h0);

        // Change pulse coinciding with a clearing read: set must win.
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step(16'h00F0, A_SW, 1'b0, 1'b1, 32'h0);
            seen = obs_chg;
        end
        check("chg_seen", {31'b0, seen}, 32'h1);
        step(16'h00F0, A_STAT, 1'b0, 1'b0, 32'h0);
        check("sticky_set_wins", obs_rdata, 32'h1);
        step(16'h00F0, A_SW, 1'b0, 1'b1, 32'h0);
        step(16'h00F0, A_STAT, 1'b0, 1'b0, 32'h0);
        check("sticky_cleared", obs_rdata, 32'h0);

        // Randomized traffic, with a reset in the middle.
        addrs = '{A_LED, A_SW, A_STAT, 32'h0000_FFFC, 32'h0000_0000, 32'h0000_FFF4};
        for (int seg = 0; seg < 2; seg++) begin
            if (seg == 1) do_reset(3, 16'($urandom));
            cur  = 16'($urandom);
            hold = 0;
            for (int i = 0; i < 1200; i++) begin
                logic [31:0] a;
                if (hold == 0) begin
                    cur  = ($urandom_range(0, 3) == 0) ? (cur ^ 16'h0001) : 16'($urandom);
                    hold = $urandom_range(1, 30);
                end
                hold--;
                a = ($urandom_range(0, 7) == 0) ? $urandom : addrs[$urandom_range(0, 5)];
                step(cur, a, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_io_regs.md
Name: mmio_io_regs

Overview:
Memory-mapped I/O register block between the MIPS CPU data-memory port and the seven-segment display driver. It holds the 4-bit LED/display value written by CPU stores and drives it to the display driver's `led` input. It also synchronises and debounces the 16 board switches and returns them, plus a sticky change flag, on CPU loads. The CPU sees it as three word addresses that sit beside data RAM.

Parameters:
DEB_TICK, 100000, clk cycles between debounce sample ticks (1 ms at 100 MHz).
TICK_W, 17, width of the tick prescaler; must hold DEB_TICK-1.
LED_ADDR, 32'h0000_FFF0, word address of the LED register (R/W).
SW_ADDR, 32'h0000_FFF4, word address of the switch register (RO).
STAT_ADDR, 32'h0000_FFF8, word address of the status register (RO).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sw  in  16  raw board switches, asynchronous to clk
mem_addr  in  32  CPU data address
mem_wdata  in  32  CPU store data
mem_we  in  1  CPU store strobe, one cycle per store
mem_re  in  1  CPU load strobe, one cycle per load
mem_rdata  out  32  load data, combinational from registered state
io_hit  out  1  combinational; 1 when mem_addr equals any of the three addresses
led  out  4  LED value to the display driver
sw_changed  out  1  one-cycle pulse when any debounced switch bit changes

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; all state updates on posedge clk.
- Values after reset:
  - led=0, sw_changed=0, debounced switches=0, sticky flag=0, prescaler=0, synchroniser flops=0.
  - mem_rdata follows the decode below.
- Synchroniser: every sw bit passes through two flops (sync1, sync2) before any other use.
- Tick prescaler:
  - Counts 0..DEB_TICK-1, then wraps to 0.
  - tick=1 for the single cycle in which the count equals DEB_TICK-1.
- Per-bit debounce:
  - On each tick, shift sync2 into a 3-bit history.
  - Debounced bit takes value v only when all 3 history bits equal v; otherwise it holds.
  - Worst-case latency from a stable input change: 2 sync cycles + 3 ticks.
- sw_changed: asserted in the cycle after the debounced vector changes, for exactly one cycle.
- Sticky flag (status bit 0):
  - Set by sw_changed.
  - Cleared by mem_re with mem_addr==SW_ADDR.
  - If set and clear occur in the same cycle, set wins.
- Write:
  - mem_we && mem_addr==LED_ADDR loads led<=mem_wdata[3:0] at the next edge.
  - Upper wdata bits are ignored.
  - Stores to SW_ADDR, STAT_ADDR or non-hit addresses have no effect.
- Read data (combinational, zero wait states, valid whenever mem_addr is stable; mem_re only matters for the sticky clear):
  - LED_ADDR -> {28'b0, led}
  - SW_ADDR -> {16'b0, debounced sw}
  - STAT_ADDR -> {31'b0, sticky}
  - any other address -> 32'b0
- Simultaneous mem_we and mem_re to LED_ADDR: the read returns the old value; the new value is visible next cycle.
- Reset mid-debounce: history and prescaler restart; no sw_changed pulse is generated by the reset itself.

Optional Feature:
DEBOUNCE_EN
- Defined: tick prescaler plus 3-sample debounce as above.
- Undefined:
  - Prescaler and history are removed.
  - Debounced vector = sync2 directly, so latency is 2 cycles.
  - sw_changed fires on any sync2 change.
  - DEB_TICK and TICK_W are unused.

Decomposition:
- Package io_pkg holds:
  - default LED_ADDR / SW_ADDR / STAT_ADDR constants;
  - STAT_SWCHG_BIT = 0;
  - 4-bit led_t and 16-bit sw_t typedefs.
- One sub-module, sw_debounce:
  - contains the synchroniser, prescaler and history;
  - parameter DEB_TICK;
  - input 16-bit raw, output 16-bit stable plus change pulse;
  - the DEBOUNCE_EN guard lives inside it.
- mmio_io_regs keeps address decode, the LED register and the sticky flag.

Test Plan:
- Reset with sw=16'hFFFF, then hold reset 2 cycles: led=0, sw_changed=0, read of SW_ADDR returns 0 until the debounce completes.
- DEB_TICK=4. Set sw=16'h0005 and hold. The SW_ADDR read becomes 32'h0000_0005 within 2+12 cycles. sw_changed pulses exactly once and the STAT_ADDR read returns 1.
- DEB_TICK=4, sw bit0 toggling every 3 cycles: the debounced value never changes and sw_changed stays 0. With DEBOUNCE_EN undefined, it follows with 2-cycle latency instead.
- Store 32'hABCD_1239 to LED_ADDR: led=4'h9 next cycle, LED_ADDR read returns 32'h9. A store to SW_ADDR leaves everything unchanged.
- sw_changed coinciding with a SW_ADDR read (mem_re=1): the sticky flag remains 1. The next SW_ADDR read with no change clears it to 0.
- Addresses 32'h0000_FFFC and 32'h0: io_hit=0 and mem_rdata=0; stores to them leave led unchanged.
